// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the adder arbiter: FSM state encoding,
// default requester count and round-robin pointer advance.
package adder_arb_pkg;

  typedef enum logic {IDLE, HOLD} arb_state_t;

  localparam int DEFAULT_NUM_REQ = 3;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Shared DATA_W-bit adder; the carry out is discarded so sums wrap modulo 2^DATA_W.
module adder #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker: grants the first set request at or after
// ptr, wrapping from NUM_REQ-1 back to 0.
module rr_picker #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int best_d;
  int d;

  // Smallest wrap distance from ptr wins; keeps every index a loop constant.
  always_comb begin
    best_d = NUM_REQ;
    d      = 0;
    idx    = '0;
    any    = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + NUM_REQ - int'(ptr)) % NUM_REQ;
      if (req[j] && d < best_d) begin
        best_d = d;
        idx    = ID_W'(j);
        any    = 1'b1;
      end
    end
  end

  always_comb begin
    gnt = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      gnt[j] = any && (idx == ID_W'(j));
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters, with a
// single registered result stage. Define ADDER_ARB_STATS_EN for grant/stall counters.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int DATA_W  = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_result,
  output logic [ID_W-1:0]           rsp_id
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [31:0]               stat_grants,
  output logic [31:0]               stat_stalls
`endif
);

  arb_state_t          state;
  logic [ID_W-1:0]     rr_ptr;
  logic                vld_p1;
  logic [DATA_W-1:0]   result_p1;
  logic [ID_W-1:0]     id_p1;

  logic                drain;
  logic                can_accept;
  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     grant_idx;
  logic                pick_any;
  logic                accept;
  logic [DATA_W-1:0]   a_p0;
  logic [DATA_W-1:0]   b_p0;
  logic [DATA_W-1:0]   sum_p0;

  // Stage p0: arbitration and operand selection
  assign drain      = vld_p1 & rsp_ready;
  assign can_accept = (state == IDLE) | drain;
  assign pick_req   = req_valid & {NUM_REQ{can_accept & rst_n}};

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req (pick_req),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (grant_idx),
    .any (pick_any)
  );

  assign req_ready = pick_gnt;
  assign accept    = pick_any;

  always_comb begin
    a_p0 = '0;
    b_p0 = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_idx == ID_W'(j)) begin
        a_p0 = req_a[j*DATA_W +: DATA_W];
        b_p0 = req_b[j*DATA_W +: DATA_W];
      end
    end
  end

  adder #(
    .DATA_W (DATA_W)
  ) u_adder (
    .a   (a_p0),
    .b   (b_p0),
    .sum (sum_p0)
  );

  // Stage p1: result register and FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      id_p1     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            result_p1 <= sum_p0;
            id_p1     <= grant_idx;
            vld_p1    <= 1'b1;
            rr_ptr    <= ID_W'(rr_next(int'(grant_idx), NUM_REQ));
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            result_p1 <= sum_p0;
            id_p1     <= grant_idx;
            vld_p1    <= 1'b1;
            rr_ptr    <= ID_W'(rr_next(int'(grant_idx), NUM_REQ));
          end else if (drain) begin
            vld_p1 <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          vld_p1 <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid  = vld_p1;
  assign rsp_result = result_p1;
  assign rsp_id     = id_p1;

`ifdef ADDER_ARB_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (accept) begin
        stat_grants <= sat_inc(stat_grants);
      end
      if ((|req_valid) && !accept) begin
        stat_stalls <= sat_inc(stat_stalls);
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: directed vectors, corner sequences
// and a randomized run against a transaction-level reference model.
module tb_adder_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_result;
  logic [IW-1:0]   rsp_id;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0]     stat_grants;
  logic [31:0]     stat_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adder_arbiter #(
    .NUM_REQ (N),
    .DATA_W  (W),
    .ID_W    (IW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_id     (rsp_id)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_grants (stat_grants),
    .stat_stalls (stat_stalls)
`endif
  );

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  // Reference model state: one result slot plus the round-robin pointer.
  int          m_ptr;
  bit          m_vld;
  logic [31:0] m_res;
  int          m_id;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{idx: 1, a: 32'h0000_1000, b: 32'd4,         sum: 32'h0000_1004};
    vecs[1] = '{idx: 2, a: 32'hFFFF_FFFF, b: 32'd2,         sum: 32'h0000_0001};
    vecs[2] = '{idx: 1, a: 32'h7FFF_FFFF, b: 32'd1,         sum: 32'h8000_0000};
    vecs[3] = '{idx: 2, a: 32'h0000_0000, b: 32'h0000_0000, sum: 32'h0000_0000};
    vecs[4] = '{idx: 0, a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, sum: 32'hFFFF_FFFE};

    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with every requester asking
    repeat (2) @(negedge clk);
    #1;
    check("reset_rsp_valid",  64'(rsp_valid),  64'd0);
    check("reset_rsp_result", 64'(rsp_result), 64'd0);
    check("reset_rsp_id",     64'(rsp_id),     64'd0);
    check("reset_req_ready",  64'(req_ready),  64'd0);

    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single-request vectors, one-cycle latency, operands scrambled after accept
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      req_valid = N'(1) << vecs[v].idx;
      set_ops(vecs[v].idx, vecs[v].a, vecs[v].b);
      rsp_ready = 1'b1;
      #1;
      check("vec_idle_valid", 64'(rsp_valid), 64'd0);
      check("vec_req_ready",  64'(req_ready), 64'(N'(1) << vecs[v].idx));
      @(negedge clk);
      req_valid = '0;
      set_ops(vecs[v].idx, $urandom, $urandom);
      #1;
      check("vec_rsp_valid",  64'(rsp_valid),  64'd1);
      check("vec_rsp_result", 64'(rsp_result), 64'(vecs[v].sum));
      check("vec_rsp_id",     64'(rsp_id),     64'(vecs[v].idx));
    end

    // Pointer is now 1: requesters 1,2 pending -> 1 wins, then reset mid-HOLD
    @(negedge clk);
    req_valid = 3'b110;
    set_ops(1, 32'h10, 32'h20);
    set_ops(2, 32'h30, 32'h40);
    rsp_ready = 1'b0;
    #1;
    check("pre_reset_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    #1;
    check("hold_valid",  64'(rsp_valid),  64'd1);
    check("hold_id",     64'(rsp_id),     64'd1);
    check("hold_result", 64'(rsp_result), 64'h30);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(rsp_valid), 64'd0);
    check("async_reset_ready", 64'(req_ready), 64'd0);

    // Release reset with all valid: 0,1,2,0,1,2 back-to-back
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      for (int i = 0; i < N; i++) set_ops(i, 32'(32'h100 * k + i), 32'(i));
      #1;
      check("rr_ready", 64'(req_ready), 64'(N'(1) << (k % N)));
      if (k > 0) begin
        check("rr_valid",  64'(rsp_valid),  64'd1);
        check("rr_id",     64'(rsp_id),     64'((k - 1) % N));
        check("rr_result", 64'(rsp_result), 64'(32'h100 * (k - 1) + 2 * ((k - 1) % N)));
      end
    end

    // Backpressure: 3 stalled cycles hold the last result (from requester 2, k=5)
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rsp_ready = 1'b0;
      #1;
      check("bp_valid",  64'(rsp_valid),  64'd1);
      check("bp_id",     64'(rsp_id),     64'd2);
      check("bp_result", 64'(rsp_result), 64'h504);
      check("bp_ready",  64'(req_ready),  64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(req_ready), 64'b001);
    check("bp_release_id",    64'(rsp_id),    64'd2);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("bp_next_valid",  64'(rsp_valid),  64'd1);
    check("bp_next_id",     64'(rsp_id),     64'd0);
    check("bp_next_result", 64'(rsp_result), 64'h500);
    @(negedge clk);
    #1;
    check("drain_valid", 64'(rsp_valid), 64'd0);
`ifdef ADDER_ARB_STATS_EN
    check("stat_grants", 64'(stat_grants), 64'd7);
    check("stat_stalls", 64'(stat_stalls), 64'd3);
`endif

    // Randomized run against the reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    m_vld = 1'b0;
    m_res = '0;
    m_id  = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int g;
      logic [N-1:0] exp_ready;
      @(negedge clk);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      g = (!m_vld || rsp_ready) ? pick(req_valid, m_ptr) : -1;
      exp_ready = (g >= 0) ? (N'(1) << g) : '0;
      check("rand_ready", 64'(req_ready), 64'(exp_ready));
      check("rand_valid", 64'(rsp_valid), 64'(m_vld));
      if (m_vld) begin
        check("rand_result", 64'(rsp_result), 64'(m_res));
        check("rand_id",     64'(rsp_id),     64'(m_id));
      end
      if (g >= 0) begin
        m_res = req_a[g*W +: W] + req_b[g*W +: W];
        m_id  = g;
        m_vld = 1'b1;
        m_ptr = (g + 1) % N;
      end else if (m_vld && rsp_ready) begin
        m_vld = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one 32-bit Adder instance among NUM_REQ requesters: PC+4 incrementer, branch-target calculator and load/store address generator.
- Round-robin arbitration with valid/ready handshakes.
- One registered result stage with backpressure.
- Sits between the fetch/decode control logic and the shared adder in the RV32I core.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 32, operand/result width
- ID_W, $clog2(NUM_REQ), width of the requester index

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester operation request
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_a  input  NUM_REQ*DATA_W  packed operand A; slice i belongs to requester i
- req_b  input  NUM_REQ*DATA_W  packed operand B
- rsp_valid  output  1  result register holds a valid sum
- rsp_ready  input  1  consumer takes result
- rsp_result  output  DATA_W  registered sum
- rsp_id  output  ID_W  index of the requester that owns rsp_result

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_result=0, rsp_id=0.
  - Round-robin pointer rr_ptr=0; FSM=IDLE.
  - req_ready is combinational and is 0 during reset.
- FSM states:
  - IDLE: output register empty.
  - HOLD: output register full.
- Grant condition: can_accept = (state==IDLE) | (rsp_valid & rsp_ready).
- Arbitration (combinational):
  - When can_accept, grant the first requester with req_valid set, searching from rr_ptr upward with wrap NUM_REQ-1 -> 0.
  - req_ready[g]=1 only for the granted index g; all others 0.
  - req_ready never asserts without req_valid.
- Transfer on req_valid[g] & req_ready[g]:
  - Next edge: rsp_result <= req_a[g] + req_b[g], truncated to DATA_W (carry discarded; wraps mod 2^DATA_W).
  - Same edge: rsp_id <= g, rsp_valid <= 1, state -> HOLD, rr_ptr <= (g+1) mod NUM_REQ.
- Latency: exactly one cycle from accept to rsp_valid.
- HOLD:
  - rsp_result and rsp_id stay stable until rsp_valid & rsp_ready.
  - Drain with no new grant the same cycle: rsp_valid <= 0, state -> IDLE.
  - Drain plus new grant the same cycle: back-to-back; stays HOLD with the new data. Throughput is 1 op/cycle when rsp_ready is held high.
- No request pending: rr_ptr is unchanged.
- Fairness: a requester that keeps req_valid high is granted within NUM_REQ accepts.
- Reset mid-operation: any held result is discarded and rsp_valid drops immediately (async). Requesters must re-issue.
- Operands are sampled only in the accept cycle. Requesters may change operands freely while not granted.

Optional Feature:
- Macro: ADDER_ARB_STATS_EN.
- When defined, two extra output ports are present:
  - stat_grants (32-bit): total accepted requests.
  - stat_stalls (32-bit): cycles where |req_valid is 1 but no grant is made.
  - Both reset to 0 and saturate at 0xFFFF_FFFF; they do not wrap.
- When undefined: the ports and counters are absent, and the functional behaviour is otherwise identical.

Decomposition:
- Package adder_arb_pkg holds:
  - typedef enum logic {IDLE, HOLD} arb_state_t
  - localparam DEFAULT_NUM_REQ=3
  - the function rr_next(ptr, n)
- Sub-module rr_picker:
  - Combinational round-robin priority picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, grant index, any.
- The adder is the existing Adder module, instantiated once with operands muxed by the grant index.

Test Plan:
- Single request, no backpressure: requester 1 with a=0x0000_1000, b=4 -> req_ready[1]=1 in cycle 0; cycle 1: rsp_valid=1, rsp_result=0x0000_1004, rsp_id=1.
- Overflow: a=0xFFFF_FFFF, b=2 -> rsp_result=0x0000_0001, no other flag.
- All three requesters valid continuously, rsp_ready=1 -> grants 0,1,2,0,1,2 on consecutive cycles; one result per cycle with matching rsp_id.
- Backpressure: rsp_ready=0 for 3 cycles after a result -> rsp_result/rsp_id stable, all req_ready=0; on rsp_ready=1 the next pending requester is granted the same cycle.
- Reset mid-HOLD: rsp_valid=1, assert rst_n=0 asynchronously -> rsp_valid=0 before the next edge; after release rr_ptr=0, so requester 0 wins if all are valid.
- With ADDER_ARB_STATS_EN: 5 accepts plus 3 backpressured cycles with pending requests -> stat_grants=5, stat_stalls=3.
